weight_instr_queue: RTL
=======================

WEIGHT_INSTR_QUEUE -- requirements
Module: weight_instr_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queued weight instructions (power of two, >=2).
REQ-002 Parameter CNT_WIDTH, default $clog2(DEPTH+1), width of occupancy count.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  global advance; low freezes all state.
REQ-006 in_instr  input  weight_instr_type  instruction to enqueue (opcode, weight_addr, length).
REQ-007 in_valid  input  1  enqueue request.
REQ-008 in_ready  output  1  queue not full.
REQ-009 flush  input  1  discard all queued, not-yet-issued instructions.
REQ-010 out_instr  output  weight_instr_type  instruction to weight flow controller, registered.
REQ-011 out_instr_enable  output  1  registered one-enabled-cycle issue pulse to weight flow controller instr_enable.
REQ-012 wfc_busy  input  1  weight flow controller busy.
REQ-013 wfc_resource_busy  input  1  weight flow controller resource_busy (pipeline tail).
REQ-014 queue_count  output  CNT_WIDTH  entries held, 0..DEPTH.
REQ-015 idle  output  1  queue empty, FSM in IDLE, wfc_resource_busy low.
REQ-016 overflow  output  1  sticky: enqueue attempted while full.

Function
REQ-017 Storage: DEPTH-entry circular FIFO, read/write pointers wrap DEPTH-1 -> 0.
REQ-018 Push when enable & in_valid & in_ready & !flush; in_ready = (queue_count != DEPTH), combinational.
REQ-019 No bypass: instruction pushed at edge N is issuable no earlier than edge N+1.
REQ-020 Simultaneous push and pop in one edge: count unchanged, both pointers advance; legal when full.
REQ-021 in_valid while full and enable high: data dropped, overflow set to 1, held until reset or flush.
REQ-022 flush (enable high): pointers and count to 0, overflow cleared, push that cycle ignored; FSM and an in-flight issue unaffected.
REQ-023 FSM states IDLE, WAIT, RUN; all transitions only on edges with enable high.
REQ-024 IDLE: if queue_count>0 and !wfc_busy and !flush -> load out_instr from head, out_instr_enable<=1, pop, go WAIT; else stay.
REQ-025 WAIT: out_instr_enable<=0 at first WAIT edge; wfc_busy=1 -> RUN; after 3 WAIT edges without wfc_busy -> IDLE (zero-length instruction tolerance).
REQ-026 RUN: wfc_busy=0 -> IDLE; else stay; no issue from RUN or WAIT.
REQ-027 Issue rate: at most one instruction per controller busy period; back-to-back issue after busy falls earliest next edge.
REQ-028 enable low: pointers, count, FSM, out_instr, out_instr_enable, overflow all hold (issue pulse stretched until an enabled edge consumes it).
REQ-029 out_instr holds last issued value between issues.
REQ-030 idle = (queue_count==0) & (state==IDLE) & !wfc_resource_busy, combinational.

Reset
REQ-031 rst_n low at edge: state IDLE, pointers 0, queue_count 0, out_instr all-zero, out_instr_enable 0, overflow 0; takes priority over enable and flush.
REQ-032 Reset mid-issue (WAIT/RUN) discards queue and returns IDLE; controller is reset by same system reset.
REQ-033 After reset: in_ready=1, idle=1 when wfc_resource_busy=0.

Verification
REQ-034 Single push weight_addr=0x10,length=5, wfc_busy low -> out_instr_enable one cycle at edge after push, out_instr.weight_addr=0x10, queue_count 1->0.
REQ-035 Push 4 while wfc_busy=1 -> queue_count=4, in_ready=0; 5th push -> overflow=1, count stays 4; release busy -> entries issued in FIFO order, one per busy period.
REQ-036 Full queue, push+pop same edge -> count stays 4, pushed entry issued last.
REQ-037 wfc_busy never rises after issue -> FSM returns IDLE after 3 edges, next entry issued.
REQ-038 enable low 5 cycles during pulse -> out_instr_enable held high, count frozen; resumes correctly.
REQ-039 flush with 3 queued and issue in WAIT -> count 0, overflow 0, in-flight completes; rst_n low in RUN -> all outputs to reset values next edge.

Source files
------------

// File: rtl/weight_instr_queue.sv
// Weight instruction queue: a DEPTH-entry FIFO feeding a weight flow controller,
// issuing at most one instruction per controller busy period through a small FSM.
module weight_instr_queue #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1),
  parameter int OP_W      = 4,
  parameter int ADDR_W    = 16,
  parameter int LEN_W     = 16,
  parameter int INSTR_W   = OP_W + ADDR_W + LEN_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [INSTR_W-1:0]   in_instr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 flush_i,
  output logic [INSTR_W-1:0]   out_instr_o,
  output logic                 out_instr_enable_o,
  input  logic                 wfc_busy_i,
  input  logic                 wfc_resource_busy_i,
  output logic [CNT_WIDTH-1:0] queue_count_o,
  output logic                 idle_o,
  output logic                 overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]     PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           wait_cnt_q, wait_cnt_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
  logic                 out_en_q, out_en_d;
  logic                 overflow_q, overflow_d;
  logic [INSTR_W-1:0]   mem_q [DEPTH];

  logic full_s;
  logic empty_s;
  logic issue_s;
  logic push_s;
  logic ovf_set_s;

  // Handshake and issue decisions; a full queue still accepts a push on an issuing edge
  always_comb begin
    full_s    = (count_q == CNT_FULL);
    empty_s   = (count_q == CNT_ZERO);
    issue_s   = enable_i & (state_q == S_IDLE) & ~empty_s & ~wfc_busy_i & ~flush_i;
    push_s    = enable_i & in_valid_i & ~flush_i & (~full_s | issue_s);
    ovf_set_s = enable_i & in_valid_i & ~flush_i & full_s & ~issue_s;
  end

  // FSM next state; WAIT gives up after three edges without the controller going busy
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (enable_i) begin
      case (state_q)
        S_IDLE: begin
          if (issue_s) begin
            state_d    = S_WAIT;
            wait_cnt_d = 2'd0;
          end else begin
            state_d    = S_IDLE;
          end
        end
        S_WAIT: begin
          if (wfc_busy_i) begin
            state_d    = S_RUN;
            wait_cnt_d = 2'd0;
          end else if (wait_cnt_q == 2'd2) begin
            state_d    = S_IDLE;
            wait_cnt_d = 2'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 2'd1;
          end
        end
        S_RUN: begin
          if (!wfc_busy_i) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d    = S_IDLE;
          wait_cnt_d = 2'd0;
        end
      endcase
    end else begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Queue bookkeeping and issue register next state; everything holds while disabled
  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    out_instr_d = out_instr_q;
    out_en_d    = out_en_q;
    if (enable_i) begin
      out_en_d = issue_s;
      if (issue_s) begin
        out_instr_d = mem_q[rptr_q];
      end else begin
        out_instr_d = out_instr_q;
      end
      if (flush_i) begin
        wptr_d     = PTR_ZERO;
        rptr_d     = PTR_ZERO;
        count_d    = CNT_ZERO;
        overflow_d = 1'b0;
      end else begin
        if (push_s) begin
          wptr_d = wptr_q + PTR_ONE;
        end else begin
          wptr_d = wptr_q;
        end
        if (issue_s) begin
          rptr_d = rptr_q + PTR_ONE;
        end else begin
          rptr_d = rptr_q;
        end
        case ({push_s, issue_s})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
        if (ovf_set_s) begin
          overflow_d = 1'b1;
        end else begin
          overflow_d = overflow_q;
        end
      end
    end else begin
      out_en_d = out_en_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 2'd0;
      wptr_q      <= PTR_ZERO;
      rptr_q      <= PTR_ZERO;
      count_q     <= CNT_ZERO;
      out_instr_q <= {INSTR_W{1'b0}};
      out_en_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_instr_q <= out_instr_d;
      out_en_q    <= out_en_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry storage; contents need no reset because the pointers gate every read
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= in_instr_i;
    end
  end

  assign in_ready_o         = ~full_s;
  assign out_instr_o        = out_instr_q;
  assign out_instr_enable_o = out_en_q;
  assign queue_count_o      = count_q;
  assign overflow_o         = overflow_q;
  assign idle_o             = empty_s & (state_q == S_IDLE) & ~wfc_resource_busy_i;

endmodule
